cpu_ctrl: RTL and testbench

- Control unit for the 8-bit accumulator CPU datapath: registers A, B, C, a 16x8 data memory, ALU and output register.
- Samples the instruction byte stream on `in` once per clock and decodes the 4-bit opcode.
- Sequences one-byte and two-byte instructions.
- Drives registered, one-cycle control pulses to the datapath; owns no data registers except the operand latch.

---
 rtl/cpu_pkg.sv | 86 ++++++++
 rtl/cpu_decode.sv | 70 +++++++
 rtl/cpu_ctrl.sv | 172 +++++++++++++++++
 tb/tb_cpu_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the 8-bit accumulator CPU. Both the datapath and
//   the controller (cpu_ctrl) import this package.
//   Contents:
//     - 4-bit opcode encodings (in[7:4] of the first instruction byte)
//     - 3-bit ALU operation codes driven on alu_op
//     - SRC_* mux-select constants for the datapath input muxes
//     - controller state enum and the per-cycle control vector
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Opcodes
  localparam logic [3:0] OP_ADD  = 4'h0;  // C <= A + B
  localparam logic [3:0] OP_SUB  = 4'h1;  // C <= A - B
  localparam logic [3:0] OP_INC  = 4'h2;  // C <= A + 1
  localparam logic [3:0] OP_DEC  = 4'h3;  // C <= A - 1
  localparam logic [3:0] OP_ADC1 = 4'h4;  // C <= A + B + 1
  localparam logic [3:0] OP_NEG  = 4'h5;  // C <= -A
  localparam logic [3:0] OP_LDA  = 4'h6;  // A <= next byte
  localparam logic [3:0] OP_LDB  = 4'h7;  // B <= next byte
  localparam logic [3:0] OP_STI  = 4'h8;  // mem[n] <= next byte
  localparam logic [3:0] OP_STC  = 4'h9;  // mem[n] <= C
  localparam logic [3:0] OP_LDM  = 4'hA;  // C <= mem[n] (two cycles)
  localparam logic [3:0] OP_OUTC = 4'hB;  // OUT <= C
  localparam logic [3:0] OP_OUTM = 4'hC;  // OUT <= mem[n] (two cycles)
  localparam logic [3:0] OP_MVA  = 4'hD;  // A <= C
  localparam logic [3:0] OP_MVB  = 4'hE;  // B <= C
  localparam logic [3:0] OP_NOP  = 4'hF;

  // ALU operations
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_INC  = 3'd2;
  localparam logic [2:0] ALU_DEC  = 3'd3;
  localparam logic [2:0] ALU_ADC1 = 3'd4;
  localparam logic [2:0] ALU_NEG  = 3'd5;

  // Datapath mux selects
  localparam logic SRC_C_ALU    = 1'b0;
  localparam logic SRC_C_MEM    = 1'b1;
  localparam logic SRC_AB_OPND  = 1'b0;
  localparam logic SRC_AB_C     = 1'b1;
  localparam logic SRC_MEM_OPND = 1'b0;
  localparam logic SRC_MEM_C    = 1'b1;
  localparam logic SRC_OUT_C    = 1'b0;
  localparam logic SRC_OUT_MEM  = 1'b1;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_OPND_A  = 3'd1,
    ST_OPND_B  = 3'd2,
    ST_OPND_M  = 3'd3,
    ST_RSV_LD  = 3'd4,
    ST_RSV_OUT = 3'd5
  } ctrl_state_t;

  // Everything the controller decides in one cycle. addr_ld / opnd_ld / retire
  // are internal enables for the address, operand and counter registers.
  typedef struct packed {
    logic [2:0]  alu_op;
    logic        c_we;
    logic        c_src;
    logic        a_we;
    logic        b_we;
    logic        ab_src;
    logic        mem_we;
    logic        mem_re;
    logic        mem_src;
    logic        addr_ld;
    logic        out_we;
    logic        out_src;
    logic        opnd_ld;
    logic        retire;
    ctrl_state_t next_state;
  } ctrl_vec_t;

  // Quiet cycle: no strobes, all selects 0, return to FETCH.
  function automatic ctrl_vec_t ctrl_idle();
    ctrl_vec_t v;
    v            = '0;
    v.next_state = ST_FETCH;
    return v;
  endfunction

endpackage : cpu_pkg

// File: rtl/cpu_decode.sv
// -----------------------------------------------------------------------------
// cpu_decode
//   Pure combinational opcode decoder used by cpu_ctrl while in FETCH.
//   Maps a 4-bit opcode to the control vector for the cycle that follows.
//   Ports:
//     i_opcode  in  4           opcode (instruction byte bits [7:4])
//     o_ctrl    out ctrl_vec_t  decoded control vector
// -----------------------------------------------------------------------------
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [3:0] i_opcode,
  output ctrl_vec_t  o_ctrl
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path can leave
    // an output unassigned, which would otherwise infer a latch.
    o_ctrl = ctrl_idle();
    unique case (i_opcode)
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_ADC1, OP_NEG: begin
        // ALU opcodes 0..5 map one-to-one onto ALU codes 0..5.
        o_ctrl.alu_op = i_opcode[2:0];
        o_ctrl.c_we   = 1'b1;
        o_ctrl.c_src  = SRC_C_ALU;
        o_ctrl.retire = 1'b1;
      end
      OP_LDA: o_ctrl.next_state = ST_OPND_A;
      OP_LDB: o_ctrl.next_state = ST_OPND_B;
      OP_STI: begin
        o_ctrl.addr_ld    = 1'b1;
        o_ctrl.next_state = ST_OPND_M;
      end
      OP_STC: begin
        o_ctrl.addr_ld = 1'b1;
        o_ctrl.mem_we  = 1'b1;
        o_ctrl.mem_src = SRC_MEM_C;
        o_ctrl.retire  = 1'b1;
      end
      OP_LDM: begin
        o_ctrl.addr_ld    = 1'b1;
        o_ctrl.mem_re     = 1'b1;
        o_ctrl.next_state = ST_RSV_LD;
      end
      OP_OUTC: begin
        o_ctrl.out_we  = 1'b1;
        o_ctrl.out_src = SRC_OUT_C;
        o_ctrl.retire  = 1'b1;
      end
      OP_OUTM: begin
        o_ctrl.addr_ld    = 1'b1;
        o_ctrl.mem_re     = 1'b1;
        o_ctrl.next_state = ST_RSV_OUT;
      end
      OP_MVA: begin
        o_ctrl.a_we   = 1'b1;
        o_ctrl.ab_src = SRC_AB_C;
        o_ctrl.retire = 1'b1;
      end
      OP_MVB: begin
        o_ctrl.b_we   = 1'b1;
        o_ctrl.ab_src = SRC_AB_C;
        o_ctrl.retire = 1'b1;
      end
      OP_NOP: o_ctrl.retire = 1'b1;
      default: o_ctrl = ctrl_idle();
    endcase
  end

endmodule : cpu_decode

// File: rtl/cpu_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_ctrl
//   Control unit for the 8-bit accumulator CPU. Samples one byte per clock,
//   sequences one- and two-byte instructions and drives registered one-cycle
//   control pulses to the datapath. A byte taken in an operand/reserved state
//   is never decoded as an opcode.
//   Ports:
//     clk        in   1       rising-edge clock
//     reset      in   1       synchronous active-high reset
//     in         in   DATA_W  instruction / operand byte stream
//     alu_op     out  3       ALU operation (holds when no ALU op issued)
//     c_we/c_src out  1/1     C load strobe / source (0 ALU, 1 mem_rdata)
//     a_we/b_we  out  1/1     A / B load strobes
//     ab_src     out  1       A/B source (0 operand latch, 1 C)
//     mem_we     out  1       memory write strobe
//     mem_re     out  1       memory read strobe
//     mem_src    out  1       write data (0 operand latch, 1 C)
//     mem_addr   out  ADDR_W  memory address, held until next memory opcode
//     out_we     out  1       output-register load strobe
//     out_src    out  1       output source (0 C, 1 mem_rdata)
//     operand    out  DATA_W  latched second byte
//     busy       out  1       waiting for a second byte
//     instr_cnt  out  CNT_W   retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in,
  output logic [2:0]        alu_op,
  output logic              c_we,
  output logic              c_src,
  output logic              a_we,
  output logic              b_we,
  output logic              ab_src,
  output logic              mem_we,
  output logic              mem_re,
  output logic              mem_src,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              out_we,
  output logic              out_src,
  output logic [DATA_W-1:0] operand,
  output logic              busy,
  output logic [CNT_W-1:0]  instr_cnt
);

  ctrl_state_t       r_state;
  ctrl_vec_t         w_dec;
  ctrl_vec_t         w_ctrl;

  logic [2:0]        r_alu_op;
  logic              r_c_we, r_c_src, r_a_we, r_b_we, r_ab_src;
  logic              r_mem_we, r_mem_re, r_mem_src, r_out_we, r_out_src;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_operand;
  logic              r_busy;
  logic [CNT_W-1:0]  r_instr_cnt;

  cpu_decode u_decode (
    .i_opcode (in[DATA_W-1 -: 4]),
    .o_ctrl   (w_dec)
  );

  // Next-state / next-output logic. Only FETCH consults the decoder; the
  // other states consume the byte as data (or ignore it) and return to FETCH.
  always_comb begin
    w_ctrl = ctrl_idle();
    unique case (r_state)
      ST_FETCH: w_ctrl = w_dec;
      ST_OPND_A: begin
        w_ctrl.a_we    = 1'b1;
        w_ctrl.ab_src  = SRC_AB_OPND;
        w_ctrl.opnd_ld = 1'b1;
        w_ctrl.retire  = 1'b1;
      end
      ST_OPND_B: begin
        w_ctrl.b_we    = 1'b1;
        w_ctrl.ab_src  = SRC_AB_OPND;
        w_ctrl.opnd_ld = 1'b1;
        w_ctrl.retire  = 1'b1;
      end
      ST_OPND_M: begin
        w_ctrl.mem_we  = 1'b1;
        w_ctrl.mem_src = SRC_MEM_OPND;
        w_ctrl.opnd_ld = 1'b1;
        w_ctrl.retire  = 1'b1;
      end
      // The read was issued the previous cycle; mem_rdata is valid now.
      ST_RSV_LD: begin
        w_ctrl.c_we   = 1'b1;
        w_ctrl.c_src  = SRC_C_MEM;
        w_ctrl.retire = 1'b1;
      end
      ST_RSV_OUT: begin
        w_ctrl.out_we  = 1'b1;
        w_ctrl.out_src = SRC_OUT_MEM;
        w_ctrl.retire  = 1'b1;
      end
      default: w_ctrl = ctrl_idle();
    endcase
  end

  // NOTE: state and output registers use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: reset clears every register here, including the operand latch,
      // so an instruction waiting for its second byte is fully discarded.
      r_state     <= ST_FETCH;
      r_alu_op    <= ALU_ADD;
      r_c_we      <= 1'b0;
      r_c_src     <= 1'b0;
      r_a_we      <= 1'b0;
      r_b_we      <= 1'b0;
      r_ab_src    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_src   <= 1'b0;
      r_mem_addr  <= '0;
      r_out_we    <= 1'b0;
      r_out_src   <= 1'b0;
      r_operand   <= '0;
      r_busy      <= 1'b0;
      r_instr_cnt <= '0;
    end else begin
      r_state   <= w_ctrl.next_state;
      r_c_we    <= w_ctrl.c_we;
      r_c_src   <= w_ctrl.c_src;
      r_a_we    <= w_ctrl.a_we;
      r_b_we    <= w_ctrl.b_we;
      r_ab_src  <= w_ctrl.ab_src;
      r_mem_we  <= w_ctrl.mem_we;
      r_mem_re  <= w_ctrl.mem_re;
      r_mem_src <= w_ctrl.mem_src;
      r_out_we  <= w_ctrl.out_we;
      r_out_src <= w_ctrl.out_src;
      r_busy    <= (w_ctrl.next_state != ST_FETCH);
      // alu_op only moves on a real ALU instruction; a memory-sourced C load
      // leaves it at its previous value.
      if (w_ctrl.c_we && (w_ctrl.c_src == SRC_C_ALU))
        r_alu_op <= w_ctrl.alu_op;
      if (w_ctrl.addr_ld)
        r_mem_addr <= in[ADDR_W-1:0];
      if (w_ctrl.opnd_ld)
        r_operand <= in;
      if (w_ctrl.retire)
        r_instr_cnt <= r_instr_cnt + CNT_W'(1);
    end
  end

  assign alu_op    = r_alu_op;
  assign c_we      = r_c_we;
  assign c_src     = r_c_src;
  assign a_we      = r_a_we;
  assign b_we      = r_b_we;
  assign ab_src    = r_ab_src;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;
  assign mem_src   = r_mem_src;
  assign mem_addr  = r_mem_addr;
  assign out_we    = r_out_we;
  assign out_src   = r_out_src;
  assign operand   = r_operand;
  assign busy      = r_busy;
  assign instr_cnt = r_instr_cnt;

endmodule : cpu_ctrl

// File: tb/tb_cpu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cpu_ctrl
//   Self-checking bench for cpu_ctrl. A table of {reset, byte, expected
//   outputs} records is applied one byte per clock; each row compares the full
//   output vector sampled 1 ns after the rising edge. A short hand-written
//   sequence then covers reset in the middle of a two-byte store.
// -----------------------------------------------------------------------------
module tb_cpu_ctrl;

  typedef struct packed {
    logic [2:0]  alu_op;
    logic        c_we;
    logic        c_src;
    logic        a_we;
    logic        b_we;
    logic        ab_src;
    logic        mem_we;
    logic        mem_re;
    logic        mem_src;
    logic [3:0]  mem_addr;
    logic        out_we;
    logic        out_src;
    logic [7:0]  operand;
    logic        busy;
    logic [15:0] cnt;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [7:0] din;
    outs_t      exp;
  } vec_t;

  localparam int NVEC = 25;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  tb_in;
  logic [2:0]  alu_op;
  logic        c_we, c_src, a_we, b_we, ab_src;
  logic        mem_we, mem_re, mem_src, out_we, out_src, busy;
  logic [3:0]  mem_addr;
  logic [7:0]  operand;
  logic [15:0] instr_cnt;

  int checks   = 0;
  int failures = 0;

  vec_t vecs [NVEC];

  cpu_ctrl #(.DATA_W(8), .ADDR_W(4), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (tb_in),
    .alu_op    (alu_op),
    .c_we      (c_we),
    .c_src     (c_src),
    .a_we      (a_we),
    .b_we      (b_we),
    .ab_src    (ab_src),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_src   (mem_src),
    .mem_addr  (mem_addr),
    .out_we    (out_we),
    .out_src   (out_src),
    .operand   (operand),
    .busy      (busy),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  function automatic outs_t mk(
    input logic [2:0] alu, input logic cwe, input logic csrc,
    input logic awe, input logic bwe, input logic absrc,
    input logic mwe, input logic mre, input logic msrc, input logic [3:0] maddr,
    input logic owe, input logic osrc, input logic [7:0] opnd,
    input logic bsy, input logic [15:0] cnt);
    outs_t o;
    o = '{alu, cwe, csrc, awe, bwe, absrc, mwe, mre, msrc, maddr,
          owe, osrc, opnd, bsy, cnt};
    return o;
  endfunction

  function automatic outs_t observed();
    outs_t o;
    o = '{alu_op, c_we, c_src, a_we, b_we, ab_src, mem_we, mem_re, mem_src,
          mem_addr, out_we, out_src, operand, busy, instr_cnt};
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one byte on the falling edge, then sample 1 ns after the rising
  // edge that consumed it.
  task automatic apply(input logic rst, input logic [7:0] din);
    @(negedge clk);
    reset = rst;
    tb_in = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    tb_in = 8'h00;

    //                rst   byte    alu cwe csr awe bwe abs mwe mre msr addr owe osr opnd  bsy cnt
    vecs[0]  = '{1'b1, 8'h00, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 0)};
    vecs[1]  = '{1'b0, 8'h6F, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 1, 0)};
    vecs[2]  = '{1'b0, 8'hFF, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 0, 8'hFF, 0, 1)};
    vecs[3]  = '{1'b0, 8'h8F, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 8'hFF, 1, 1)};
    vecs[4]  = '{1'b0, 8'hFF, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'hF, 0, 0, 8'hFF, 0, 2)};
    vecs[5]  = '{1'b0, 8'hA3, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'h3, 0, 0, 8'hFF, 1, 2)};
    vecs[6]  = '{1'b0, 8'hFF, mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 4'h3, 0, 0, 8'hFF, 0, 3)};
    vecs[7]  = '{1'b0, 8'h07, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 4'h3, 0, 0, 8'hFF, 0, 4)};
    vecs[8]  = '{1'b0, 8'h1A, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 4'h3, 0, 0, 8'hFF, 0, 5)};
    vecs[9]  = '{1'b0, 8'h2B, mk(2, 1, 0, 0, 0, 0, 0, 0, 0, 4'h3, 0, 0, 8'hFF, 0, 6)};
    vecs[10] = '{1'b0, 8'h3C, mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 4'h3, 0, 0, 8'hFF, 0, 7)};
    vecs[11] = '{1'b0, 8'h4D, mk(4, 1, 0, 0, 0, 0, 0, 0, 0, 4'h3, 0, 0, 8'hFF, 0, 8)};
    vecs[12] = '{1'b0, 8'h5E, mk(5, 1, 0, 0, 0, 0, 0, 0, 0, 4'h3, 0, 0, 8'hFF, 0, 9)};
    vecs[13] = '{1'b0, 8'hD0, mk(5, 0, 0, 1, 0, 1, 0, 0, 0, 4'h3, 0, 0, 8'hFF, 0, 10)};
    vecs[14] = '{1'b0, 8'hE0, mk(5, 0, 0, 0, 1, 1, 0, 0, 0, 4'h3, 0, 0, 8'hFF, 0, 11)};
    vecs[15] = '{1'b0, 8'hB0, mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 4'h3, 1, 0, 8'hFF, 0, 12)};
    vecs[16] = '{1'b0, 8'h95, mk(5, 0, 0, 0, 0, 0, 1, 0, 1, 4'h5, 0, 0, 8'hFF, 0, 13)};
    vecs[17] = '{1'b0, 8'hF5, mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 4'h5, 0, 0, 8'hFF, 0, 14)};
    vecs[18] = '{1'b0, 8'h7A, mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 4'h5, 0, 0, 8'hFF, 1, 14)};
    vecs[19] = '{1'b0, 8'h12, mk(5, 0, 0, 0, 1, 0, 0, 0, 0, 4'h5, 0, 0, 8'h12, 0, 15)};
    vecs[20] = '{1'b0, 8'hC8, mk(5, 0, 0, 0, 0, 0, 0, 1, 0, 4'h8, 0, 0, 8'h12, 1, 15)};
    vecs[21] = '{1'b0, 8'h00, mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 4'h8, 1, 1, 8'h12, 0, 16)};
    vecs[22] = '{1'b0, 8'hC1, mk(5, 0, 0, 0, 0, 0, 0, 1, 0, 4'h1, 0, 0, 8'h12, 1, 16)};
    vecs[23] = '{1'b1, 8'hFF, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 8'h00, 0, 0)};
    vecs[24] = '{1'b0, 8'hB0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 8'h00, 0, 1)};

    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i].rst, vecs[i].din);
      check($sformatf("vec%0d in=%h", i, vecs[i].din),
            64'(observed()), 64'(vecs[i].exp));
    end

    // Reset while a two-byte store waits for its data byte: the write is
    // dropped, nothing is counted, and the following FF decodes as a NOP.
    apply(1'b0, 8'h84);
    check("sti_busy",      64'(busy),      64'(1));
    check("sti_addr",      64'(mem_addr),  64'(4'h4));
    apply(1'b1, 8'hAB);
    check("abort_mem_we",  64'(mem_we),    64'(0));
    check("abort_cnt",     64'(instr_cnt), 64'(0));
    check("abort_operand", 64'(operand),   64'(0));
    check("abort_addr",    64'(mem_addr),  64'(0));
    apply(1'b0, 8'hFF);
    check("post_nop_we",   64'(mem_we),    64'(0));
    check("post_nop_cnt",  64'(instr_cnt), 64'(1));
    check("post_nop_busy", 64'(busy),      64'(0));

    // A strobe lasts exactly one cycle.
    apply(1'b0, 8'hB7);
    check("outc_pulse",    64'(out_we),    64'(1));
    apply(1'b0, 8'hF0);
    check("outc_no_repeat", 64'(out_we),   64'(0));
    check("final_cnt",     64'(instr_cnt), 64'(3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_cpu_ctrl
